// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: gathers an A, B, OP byte frame, drives the ALU from registers and
// returns the captured result over valid/ready. Optional inter-byte timeout: `define ALU_SEQ_TIMEOUT_EN.
module alu_operand_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int MODE_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_alu_A,
    output logic [DATA_WIDTH-1:0] o_alu_B,
    output logic [MODE_WIDTH-1:0] o_alu_mode,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [MODE_WIDTH-1:0] r_alu_mode;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_busy;

    logic                  w_collecting;
    logic                  w_abort;

    // Partial frame in progress: only these states can time out.
    assign w_collecting = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer;
    logic          r_timeout;

    assign w_abort   = w_collecting && !i_rx_valid && (r_timer == TIMER_LAST);
    assign o_timeout = r_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_abort;
            if (!w_collecting || i_rx_valid || w_abort) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end
`else
    // Partial frames wait forever; the comparison is constant-false and only keeps
    // TIMEOUT_CYCLES referenced in this build.
    assign w_abort   = (TIMEOUT_CYCLES < 0);
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_WAIT_A;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_mode <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_A: begin
                    if (i_rx_valid) begin
                        r_alu_a <= i_rx_data;
                        r_state <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (i_rx_valid) begin
                        r_alu_b <= i_rx_data;
                        r_state <= S_WAIT_OP;
                    end else if (w_abort) begin
                        r_state <= S_WAIT_A;
                    end
                end
                S_WAIT_OP: begin
                    if (i_rx_valid) begin
                        r_alu_mode <= i_rx_data[MODE_WIDTH-1:0];
                        r_busy     <= 1'b1;
                        r_state    <= S_EXEC;
                    end else if (w_abort) begin
                        r_state <= S_WAIT_A;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for a full cycle, so the ALU output is settled.
                    r_tx_data  <= i_alu_result;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (r_tx_valid && i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_WAIT_A;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_WAIT_A;
                end
            endcase
        end
    end

    assign o_alu_A    = r_alu_a;
    assign o_alu_B    = r_alu_b;
    assign o_alu_mode = r_alu_mode;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;

endmodule
